// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_pkg
//  Purpose  : Shared definitions for the ADC burst-capture block.
//             - FSM state encoding (IDLE / ARMED / CAPTURE / DONE)
//             - Default sample width, FIFO address width, burst length and
//               decimation factor
//  Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Capture FSM state encoding. The values are fixed because downstream
    // debug tooling decodes the raw two-bit state.
    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t CAPTURE = 2'd2;
    localparam state_t DONE    = 2'd3;

    // Default build configuration
    localparam int          c_DW_DEFAULT      = 12;
    localparam int          c_FIFO_AW_DEFAULT = 10;
    localparam logic [15:0] c_NSAMP_DEFAULT   = 16'h0400;
    localparam logic [15:0] c_DECIM_DEFAULT   = 16'h0001;

endpackage
`default_nettype wire

// File: rtl/adc_cap_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : adc_cap_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO with occupancy output.
//             The head word is presented on o_rd_data whenever o_rd_valid is
//             high. A write into a full FIFO is still accepted when a read
//             happens in the same cycle.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             i_wr_en         - write request
//             i_wr_data [W]   - write data
//             o_wr_accept     - write request was taken this cycle
//             o_rd_data [W]   - head word (0 while empty)
//             o_rd_valid      - FIFO non-empty
//             i_rd_ready      - consumer takes the head word
//             o_fill [AW+1]   - current occupancy, 0 .. 2**AW
//  Revision : 1.0 - initial release
// ============================================================================
module adc_cap_fifo
    import adc_pkg::*;
#(
    parameter int W  = c_DW_DEFAULT + 1,
    parameter int AW = c_FIFO_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    output logic          o_wr_accept,
    output logic [W-1:0]  o_rd_data,
    output logic          o_rd_valid,
    input  logic          i_rd_ready,
    output logic [AW:0]   o_fill
);

    localparam int          c_DEPTH = 2 ** AW;
    localparam logic [AW:0] c_FULL  = (AW + 1)'(c_DEPTH);

    logic [W-1:0]  r_mem [c_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;

    // Pointers alone cannot tell full from empty; the extra fill bit can.
    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == c_FULL);
    assign w_rd    = ~w_empty & i_rd_ready;
    // When full, a simultaneous read frees the slot being written: the read
    // sees the old head combinationally before the write lands at the edge.
    assign w_wr    = i_wr_en & (~w_full | w_rd);

    assign o_wr_accept = w_wr;
    assign o_rd_valid  = ~w_empty;
    assign o_rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_fill      = r_fill;

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + (AW + 1)'(1);
                2'b01:   r_fill <= r_fill - (AW + 1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
//  Module   : adc_capture
//  Purpose  : Triggered burst capture of parallel ADC samples. Once the ADC
//             reports ready, waits for a rising trigger edge, stores NSAMP
//             samples (one every DECIM cycles) into an FWFT FIFO and hands
//             them out over valid/ready.
//  Options  : ADC_CAPTURE_TESTPAT_EN - when defined, a ramp counter replaces
//             the ADC data at the FIFO write point (otr bit forced to 0).
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             adc_d [DW]      - ADC parallel data
//             adc_otr         - ADC out-of-range flag
//             adc_rdy         - ADC configuration complete (level)
//             trig            - capture trigger, rising edge
//             m_data [DW+1]   - {otr, sample} at FIFO head
//             m_valid         - FIFO non-empty
//             m_ready         - consumer accepts the word
//             busy            - capture in progress
//             overflow        - sticky: a sample was dropped this burst
//             fill [FIFO_AW+1]- FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module adc_capture
    import adc_pkg::*;
#(
    parameter int          DW      = c_DW_DEFAULT,
    parameter int          FIFO_AW = c_FIFO_AW_DEFAULT,
    parameter logic [15:0] NSAMP   = c_NSAMP_DEFAULT,
    parameter logic [15:0] DECIM   = c_DECIM_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    adc_d,
    input  logic             adc_otr,
    input  logic             adc_rdy,
    input  logic             trig,
    output logic [DW:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             overflow,
    output logic [FIFO_AW:0] fill
);

    localparam logic [15:0] c_NSAMP_M1 = NSAMP - 16'd1;
    localparam logic [15:0] c_DECIM_M1 = DECIM - 16'd1;

    // Two-stage input pipeline
    logic [DW-1:0] r_d1;
    logic [DW-1:0] r_d2;
    logic          r_otr1;
    logic          r_otr2;

    // Trigger edge detection
    logic   r_trig_q;
    logic   r_edge;
    logic   w_edge;

    // Control
    state_t      r_state;
    logic [15:0] r_scnt;
    logic [15:0] r_dcnt;
    logic        r_ovf;

    logic        w_start;
    logic        w_wr_issue;
    logic        w_last;
    logic        w_wr_accept;
    logic [DW:0] w_wr_data;
    logic        w_m_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1     <= '0;
            r_d2     <= '0;
            r_otr1   <= 1'b0;
            r_otr2   <= 1'b0;
            r_trig_q <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_d1     <= adc_d;
            r_d2     <= r_d1;
            r_otr1   <= adc_otr;
            r_otr2   <= r_otr1;
            r_trig_q <= trig;
            r_edge   <= w_edge;
        end
    end

    // The edge is registered once more so the FSM reacts one cycle after
    // detection; this lines the first write up with the trigger-cycle sample.
    assign w_edge     = trig & ~r_trig_q;
    assign w_start    = (r_state == ARMED) & r_edge & adc_rdy;
    assign w_wr_issue = (r_state == CAPTURE) & (r_dcnt == 16'd0);
    assign w_last     = w_wr_issue & (r_scnt == c_NSAMP_M1);

    // FSM. Losing adc_rdy wins over every other transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (!adc_rdy) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    r_state <= ARMED;
                ARMED:   if (r_edge)     r_state <= CAPTURE;
                CAPTURE: if (w_last)     r_state <= DONE;
                DONE:    if (!w_m_valid) r_state <= ARMED;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sample and decimation counters. The sample counter advances on every
    // issued write, dropped or not, so burst length is fixed in time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt <= 16'd0;
            r_dcnt <= 16'd0;
        end else if (w_start) begin
            r_scnt <= 16'd0;
            r_dcnt <= 16'd0;
        end else if (r_state == CAPTURE) begin
            if (w_wr_issue) begin
                r_scnt <= w_last ? 16'd0 : r_scnt + 16'd1;
            end
            r_dcnt <= (r_dcnt == c_DECIM_M1) ? 16'd0 : r_dcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_ovf <= 1'b0;
        end else if (w_wr_issue && !w_wr_accept) begin
            r_ovf <= 1'b1;
        end
    end

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [DW-1:0] r_ramp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp <= '0;
        end else if (w_start) begin
            r_ramp <= '0;
        end else if (w_wr_issue) begin
            r_ramp <= r_ramp + DW'(1);
        end
    end

    assign w_wr_data = {1'b0, r_ramp};
`else
    assign w_wr_data = {r_otr2, r_d2};
`endif

    adc_cap_fifo #(
        .W  (DW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_wr_issue),
        .i_wr_data   (w_wr_data),
        .o_wr_accept (w_wr_accept),
        .o_rd_data   (m_data),
        .o_rd_valid  (w_m_valid),
        .i_rd_ready  (m_ready),
        .o_fill      (fill)
    );

    assign m_valid  = w_m_valid;
    assign busy     = (r_state == CAPTURE);
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Downstream neighbour of the ADC serial-init sequencer.
- Once the ADC is configured (adc_rdy high), it waits for a trigger and captures a fixed-length burst of parallel ADC samples with the out-of-range flag.
- Optional decimation is applied to the burst.
- The burst is buffered in an on-chip FWFT FIFO and handed to the comm/readout path over a valid/ready interface.

Parameters:
- DW, 12: ADC sample width in bits.
- FIFO_AW, 10: FIFO address width; depth = 2**FIFO_AW words.
- NSAMP, 16'h0400: samples per burst; legal range 1..65535.
- DECIM, 16'h0001: store one sample every DECIM cycles; legal range 1..65535.

Ports:
- clk  in  1  system clock; the ADC data bus is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- adc_d  in  DW  ADC parallel data.
- adc_otr  in  1  ADC out-of-range flag.
- adc_rdy  in  1  level; high = ADC init sequence complete.
- trig  in  1  trigger; acts on its rising edge.
- m_data  out  DW+1  {otr, sample}, FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the word.
- busy  out  1  high in CAPTURE.
- overflow  out  1  sticky: at least one sample was dropped in the current/last burst.
- fill  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - Outputs: m_valid=0, m_data=0, busy=0, overflow=0, fill=0.
  - Internal: state=IDLE, FIFO empty, all counters 0, input pipeline 0.
- Input path:
  - adc_d and adc_otr pass through 2 register stages.
  - A sample present on the pins in cycle t is the value written in cycle t+2.
- Trigger edge:
  - trig is registered once (trig_q).
  - Edge = trig & ~trig_q.
  - The edge is acted on in the cycle after it is detected.
- FSM states IDLE, ARMED, CAPTURE, DONE:
  - IDLE -> ARMED when adc_rdy=1.
  - ARMED -> CAPTURE on a trigger edge. In the same cycle: sample counter = 0, decimation counter = 0, overflow cleared.
  - In CAPTURE, each cycle with decimation counter = 0:
    - Issue a write of the pipelined sample and increment the sample counter.
    - The decimation counter counts 0..DECIM-1 and wraps.
  - CAPTURE -> DONE on the cycle the NSAMP-th write is issued. Exactly NSAMP writes are issued per burst.
  - DONE -> ARMED when the FIFO is empty (m_valid=0) and adc_rdy=1.
  - adc_rdy=0 in any state -> IDLE next cycle:
    - An in-progress burst is aborted.
    - Samples already in the FIFO are kept and continue to drain.
  - Trigger edges in CAPTURE, DONE or IDLE are ignored; they are not queued.
  - busy=1 exactly while state=CAPTURE.
- FIFO:
  - Synchronous, first-word-fall-through: m_data is valid whenever m_valid=1.
  - A transfer occurs when m_valid & m_ready.
  - m_data is held stable while m_valid=1 and m_ready=0.
- Write accept rule: a write is accepted if the FIFO is not full, or if a read occurs in the same cycle. Full + simultaneous read: both happen and fill stays at 2**FIFO_AW.
- Overflow handling:
  - A rejected write drops that sample and sets overflow.
  - The sample counter still advances, so burst duration is fixed in time.
  - overflow stays set until the next accepted trigger edge.
- Empty read: m_ready with m_valid=0 has no effect.
- Write to an empty FIFO: m_valid rises the cycle after the write.
- fill: updated every cycle; +1 on write only, -1 on read only, unchanged on both or neither.
- Pointers: FIFO_AW bits, wrap modulo depth. Full/empty are distinguished by the extra fill bit.
- Counter arithmetic is 16-bit unsigned; counters never exceed NSAMP-1 or DECIM-1.

Optional Feature:
- Macro: ADC_CAPTURE_TESTPAT_EN.
- When defined:
  - A DW-bit ramp counter replaces the pipelined adc_d at the FIFO write point; otr bit = 0.
  - The ramp resets to 0 on each accepted trigger edge and increments by 1 per issued write (accepted or dropped), wrapping at 2**DW.
- When undefined: there is no ramp logic and live ADC data is stored. Timing and FSM are identical in both builds.

Decomposition:
- Shared package adc_pkg:
  - FSM state typedef: IDLE=2'd0, ARMED=2'd1, CAPTURE=2'd2, DONE=2'd3.
  - Default DW, FIFO_AW, NSAMP constants.
- One sub-module: adc_cap_fifo, the parameterised FWFT sync FIFO with fill output. Its reset is also async active-high.

Test Plan:
- Reset/arm: rst pulse, adc_rdy=0 -> all outputs 0, state IDLE. adc_rdy=1 -> ARMED, busy=0, m_valid=0.
- Basic burst:
  - Settings: NSAMP=8, DECIM=1, m_ready=1, adc_d ramping 0x000,0x001,... from cycle 0, trigger edge detected at cycle 10.
  - Expected: exactly 8 words out, consecutive values; the first value equals the adc_d applied 2 cycles before the first write.
  - busy is high for 8 cycles; then DONE -> ARMED.
- Decimation: NSAMP=4, DECIM=3, constant-ramp adc_d -> 4 words whose values differ by 3; busy high for 10 cycles.
- Overflow/backpressure:
  - Settings: FIFO_AW=2, NSAMP=10, m_ready=0.
  - Expected during burst: fill saturates at 4, overflow=1, busy still exactly 10 cycles.
  - After m_ready=1: exactly 4 words are read, each equal to the first 4 captured samples.
  - Next trigger edge clears overflow.
- Full with simultaneous read: FIFO full, m_ready=1 during a write cycle -> no drop, fill stays 4, overflow stays 0.
- Abort/ignored trigger:
  - adc_rdy deasserted mid-burst after 3 writes -> IDLE, 3 words still drain.
  - A trigger edge in DONE -> no new burst; write count unchanged.
